// File: rtl/atendente_fila.sv
// Service controller for the household priority line (TV > PC > Alexa).
// Grants one device at a time for a bounded slot, then a one-cycle guard gap.
module atendente_fila #(
  parameter int SLOT_CYCLES = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TV,
  input  logic                 PC,
  input  logic                 Alexa,
  input  logic                 liberar,
  output logic                 s1,
  output logic                 s2,
  output logic                 s3,
  output logic                 ocupado,
  output logic [2:0]           pendente,
  output logic [CNT_WIDTH-1:0] atendidos
);

  typedef enum logic [1:0] {
    OCIOSO,
    ATENDE,
    INTERVALO
  } estado_t;

  localparam logic [7:0]           SLOT = 8'(SLOT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] UM   = CNT_WIDTH'(1);

  estado_t    estado;
  logic [7:0] timer;
  logic [2:0] req;
  logic [2:0] grant;
  logic [2:0] cand;
  logic [2:0] win;

  assign req   = {TV, PC, Alexa};
  assign grant = {s1, s2, s3};
  assign cand  = pendente | req;

  // Fixed priority: TV wins over PC, PC over Alexa.
  always_comb begin
    win = 3'b000;
    if (cand[2])      win = 3'b100;
    else if (cand[1]) win = 3'b010;
    else if (cand[0]) win = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= OCIOSO;
      timer        <= 8'd0;
      {s1, s2, s3} <= 3'b000;
      ocupado      <= 1'b0;
      pendente     <= 3'b000;
      atendidos    <= '0;
    end else begin
      unique case (estado)
        ATENDE: begin
          // The served device's own request is masked off.
          pendente <= pendente | (req & ~grant);
          if (liberar || timer == SLOT) begin
            estado       <= INTERVALO;
            timer        <= 8'd0;
            {s1, s2, s3} <= 3'b000;
            ocupado      <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          // Gap end and idle both pick the next winner, so queued
          // requests run grant, gap, grant.
          if (|cand) begin
            estado       <= ATENDE;
            timer        <= 8'd1;
            {s1, s2, s3} <= win;
            ocupado      <= 1'b1;
            pendente     <= cand & ~win;
            atendidos    <= atendidos + UM;
          end else begin
            estado   <= OCIOSO;
            pendente <= cand;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atendente_fila.sv
// Directed bench for atendente_fila.
// Hand-computed expectations, one checking task.
module tb_atendente_fila;

  logic       clk = 1'b0;
  logic       rst;
  logic       TV, PC, Alexa, liberar;
  logic       s1, s2, s3, ocupado;
  logic [2:0] pendente;
  logic [7:0] atendidos;

  int n_chk = 0;
  int n_ok  = 0;

  atendente_fila #(
    .SLOT_CYCLES(4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .TV       (TV),
    .PC       (PC),
    .Alexa    (Alexa),
    .liberar  (liberar),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .ocupado  (ocupado),
    .pendente (pendente),
    .atendidos(atendidos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 32'($onehot0({s1, s2, s3})), 32'd1);
  endtask

  task automatic set_req(input logic t, input logic p, input logic a);
    TV = t; PC = p; Alexa = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 0, 0);
    liberar = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] gv();
    return {s1, s2, s3, ocupado};
  endfunction

  logic [3:0] e;

  initial begin
    rst = 1'b1;
    liberar = 1'b0;
    set_req(1, 1, 1);

    // reset with all requests held
    tick();
    tick();
    chk("rst_grant", 32'(gv()), 32'h0);
    chk("rst_pend", 32'(pendente), 32'h0);
    chk("rst_cnt", 32'(atendidos), 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_rel_grant", 32'(gv()), 32'b1001);
    chk("rst_rel_pend", 32'(pendente), 32'b011);

    // single Alexa pulse
    do_reset();
    set_req(0, 0, 1);
    tick();
    set_req(0, 0, 0);
    chk("single_c1", 32'(gv()), 32'b0011);
    chk("single_cnt", 32'(atendidos), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold", 32'(gv()), 32'b0011);
    end
    tick();
    chk("single_gap", 32'(gv()), 32'b0000);
    tick();
    chk("single_idle", 32'(gv()), 32'b0000);
    chk("single_cnt_end", 32'(atendidos), 32'd1);

    // simultaneous requests
    do_reset();
    set_req(1, 1, 1);
    tick();
    set_req(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      e = 4'b0000;
      if (i < 15 && (i % 5) < 4) e = {3'b100 >> (i / 5), 1'b1};
      chk($sformatf("simul_%0d", i), 32'(gv()), 32'(e));
      if (i == 0) chk("simul_pend0", 32'(pendente), 32'b011);
      if (i == 5) chk("simul_pend5", 32'(pendente), 32'b001);
      if (i == 10) chk("simul_pend10", 32'(pendente), 32'b000);
    end
    chk("simul_cnt", 32'(atendidos), 32'd3);

    // no preemption
    do_reset();
    set_req(0, 1, 0);
    tick();
    set_req(0, 0, 0);
    chk("nopre_c1", 32'(gv()), 32'b0101);
    tick();
    set_req(1, 0, 0);
    tick();
    set_req(0, 0, 0);
    chk("nopre_c3", 32'(gv()), 32'b0101);
    chk("nopre_pend", 32'(pendente), 32'b100);
    tick();
    chk("nopre_c4", 32'(gv()), 32'b0101);
    tick();
    chk("nopre_gap", 32'(gv()), 32'b0000);
    tick();
    chk("nopre_tv", 32'(gv()), 32'b1001);
    chk("nopre_cnt", 32'(atendidos), 32'd2);

    // early release, own-channel rule
    do_reset();
    set_req(1, 0, 0);
    tick();
    chk("early_c1", 32'(gv()), 32'b1001);
    tick();
    chk("early_c2", 32'(gv()), 32'b1001);
    chk("early_pend", 32'(pendente), 32'b000);
    liberar = 1'b1;
    tick();
    chk("early_gap", 32'(gv()), 32'b0000);
    chk("early_pend_gap", 32'(pendente), 32'b000);
    liberar = 1'b0;
    set_req(0, 0, 0);
    tick();
    chk("early_noregrant", 32'(gv()), 32'b0000);
    set_req(1, 0, 0);
    tick();
    set_req(0, 0, 0);
    chk("early_regrant", 32'(gv()), 32'b1001);
    chk("early_cnt", 32'(atendidos), 32'd2);

    // counter wrap: one grant every two cycles
    do_reset();
    set_req(0, 0, 1);
    liberar = 1'b1;
    for (int i = 0; i < 510; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wrap_255", 32'(atendidos), 32'd255);
    tick();
    chk("wrap_0", 32'(atendidos), 32'd0);
    chk("wrap_grant", 32'(gv()), 32'b0011);
    set_req(0, 0, 0);
    liberar = 1'b0;

    // reset in the 3rd cycle of a slot
    do_reset();
    set_req(0, 1, 0);
    tick();
    set_req(1, 0, 0);
    tick();
    set_req(0, 0, 0);
    chk("mid_pend", 32'(pendente), 32'b100);
    tick();
    chk("mid_c3", 32'(gv()), 32'b0101);
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(gv()), 32'b0000);
    chk("mid_rst_pend", 32'(pendente), 32'b000);
    chk("mid_rst_cnt", 32'(atendidos), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_after", 32'(gv()), 32'b0000);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/atendente_fila.md
Name: atendente_fila

Overview:
Sequential service controller for the household device priority line (TV > PC > Alexa).
- Latches service requests from the three devices.
- Grants exactly one device at a time for a bounded service slot, in fixed priority order.
- Requests that arrive while a device is being served are held until the slot ends.
- Serves as the consumer end of the priority queue: the priority queue decides who may go next; this block decides when that device is actually served and for how long.

Parameters:
- SLOT_CYCLES, 4, number of clock cycles a grant is held unless released early (legal range 1..255).
- CNT_WIDTH, 8, width of the served-grants counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- TV  input  1  service request from TV, level-sampled every cycle.
- PC  input  1  service request from PC, level-sampled every cycle.
- Alexa  input  1  service request from Alexa, level-sampled every cycle.
- liberar  input  1  early release: the granted device finished before the slot expired.
- s1  output  1  grant to TV, registered.
- s2  output  1  grant to PC, registered.
- s3  output  1  grant to Alexa, registered.
- ocupado  output  1  high while any grant is active, registered.
- pendente  output  3  latched pending requests {TV,PC,Alexa}, registered.
- atendidos  output  CNT_WIDTH  count of grants issued, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst sampled on the rising edge of clk).
- Reset values: s1=s2=s3=0, ocupado=0, pendente=3'b000, atendidos=0, FSM=OCIOSO, slot timer=0.
- Reset has priority over every other input. Reset asserted mid-slot drops the grant at that edge and discards all pending requests.
- Request latching: each cycle, pendente bit i is set if its request input is 1. The bit is cleared at the edge where that device's grant starts.
- Own-channel rule: while a device is granted, its own request input is ignored. It must re-request after the slot to be served again.
- Priority: TV > PC > Alexa. The winner is picked from (pendente | current request inputs).
- FSM states:
  - OCIOSO: no grant. If the candidate set is non-zero, go to ATENDE at the next edge, with the winner's grant=1, ocupado=1, timer=1, atendidos+1, and the winner's pendente bit cleared. Latency from a request sampled at edge n to grant high is 1 cycle (grant visible after edge n).
  - ATENDE: the grant is held constant (exactly one of s1..s3 high).
    - If liberar=1 or timer==SLOT_CYCLES, go to INTERVALO at the next edge.
    - Otherwise timer+1.
    - A grant therefore lasts at most SLOT_CYCLES cycles and at least 1 cycle.
  - INTERVALO: exactly one cycle with s1=s2=s3=0 and ocupado=0 (a guard gap), then go to OCIOSO. A higher-priority request never preempts an active slot.
  - OCIOSO is re-entered after the gap, so back-to-back pending requests give grant, gap, grant.
- Grants are always one-hot or all-zero. Two grant bits high at once is a design error.
- atendidos wraps modulo 2^CNT_WIDTH (255 -> 0 for the default).
- Simultaneous requests: all are latched. They are served in priority order, one slot each, separated by one-cycle gaps.
- liberar is ignored in OCIOSO and INTERVALO.

Test Plan:
- Reset: rst=1 for 2 cycles with TV=PC=Alexa=1 -> all outputs 0 and pendente=000 while rst=1. Then deassert rst -> s1=1 on the next edge.
- Single request: Alexa pulsed for 1 cycle (SLOT_CYCLES=4) -> s3=1 for exactly 4 cycles, then 1 gap cycle with ocupado=0. atendidos goes 0->1.
- Simultaneous requests: TV=PC=Alexa=1 pulsed together for 1 cycle -> pendente=011 after TV's grant starts. Sequence is s1 x4, gap, s2 x4, gap, s3 x4, gap. atendidos ends at 3. Check one-hot throughout.
- No preemption: PC granted, TV requested in PC's 2nd cycle -> PC keeps s2 for all 4 cycles, pendente[2]=1. s1 rises after the gap cycle.
- Early release: TV granted, liberar=1 in its 2nd grant cycle -> s1 is high for exactly 2 cycles, then the gap follows. A TV request held during the grant is ignored; a TV request held after the gap is re-granted.
- Counter wrap and reset mid-slot: 256 single grants -> atendidos wraps to 0. Then rst=1 during the 3rd cycle of a slot -> grant drops at that edge and pendente=000.
